// File: rtl/data_mem.sv
// Purpose : MEM-stage data RAM with byte/half/word loads and stores, sign/zero extension, alignment check.
// Latency : load data is combinational in the completing cycle; stores commit on the edge that ends it.
// Backpr. : StallMem holds the pipeline for WAIT_CYCLES cycles per access; request inputs must stay stable.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset (zeroes the array)
//   MemReadM        load request
//   MemWriteM       store request
//   MemOpM          000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, 101-111 lw
//   AddrM           byte address; high bits above the array size wrap
//   WDM             store data (low byte/half used for sb/sh)
//   MemRDM          extended load data to MEM/WB (0 when not reading or misaligned)
//   StallMem        access not complete this cycle
//   AddrErrM        misaligned access
module data_mem #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  MemOpM,
  input  logic [31:0] AddrM,
  input  logic [31:0] WDM,
  output logic [31:0] MemRDM,
  output logic        StallMem,
  output logic        AddrErrM
);

  localparam int AW = $clog2(DEPTH_WORDS);
  // Counter preload for the WAIT state; guarded so WAIT_CYCLES=0 never produces -1.
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [0:0] {IDLE, WAIT} stateT;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] wordIdx;
  logic          unusedAddrBits;
  logic          req;
  logic          isHalf;
  logic          isByte;
  logic          isWord;
  logic          writeEn;
  logic [31:0]   curWord;
  logic [7:0]    byteSel;
  logic [15:0]   halfSel;
  logic [31:0]   loadVal;

  stateT         state;
  stateT         nextState;
  logic [3:0]    cnt;
  logic [3:0]    nextCnt;

  assign wordIdx        = AddrM[AW+1:2];
  assign unusedAddrBits = ^AddrM[31:AW+2];
  assign req            = MemReadM | MemWriteM;

  // Access size decode; unused encodings fall back to word.
  always_comb begin
    isHalf = (MemOpM == 3'b001) || (MemOpM == 3'b010);
    isByte = (MemOpM == 3'b011) || (MemOpM == 3'b100);
    isWord = !isHalf && !isByte;
  end

  assign AddrErrM = req & ((isWord & (AddrM[1:0] != 2'b00)) | (isHalf & AddrM[0]));

  // ---------------- wait-state sequencer ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
    end
  end

  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    case (state)
      IDLE: begin
        if (req && (WAIT_CYCLES != 0)) begin
          nextState = WAIT;
          nextCnt   = CNT_INIT;
        end
      end
      WAIT: begin
        if (!req) begin
          // Request withdrawn: abandon the access without writing.
          nextState = IDLE;
          nextCnt   = '0;
        end else if (cnt != 4'd0) begin
          nextCnt = cnt - 4'd1;
        end else begin
          nextState = IDLE;
        end
      end
      default: begin
        nextState = IDLE;
        nextCnt   = '0;
      end
    endcase
  end

  always_comb begin
    StallMem = 1'b0;
    case (state)
      IDLE:    StallMem = req & (WAIT_CYCLES != 0);
      WAIT:    StallMem = req & (cnt != 4'd0);
      default: StallMem = 1'b0;
    endcase
    if (reset) StallMem = 1'b0;
  end

  // ---------------- storage ----------------
  // The commit happens on the edge that ends the completing cycle, so a read in
  // the same cycle still sees the old word.
  assign writeEn = MemWriteM & ~StallMem & ~AddrErrM & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (writeEn) begin
      if (isByte) begin
        mem[wordIdx][{AddrM[1:0], 3'b000} +: 8] <= WDM[7:0];
      end else if (isHalf) begin
        if (AddrM[1]) mem[wordIdx][31:16] <= WDM[15:0];
        else          mem[wordIdx][15:0]  <= WDM[15:0];
      end else begin
        mem[wordIdx] <= WDM;
      end
    end
  end

  // ---------------- load path ----------------
  always_comb begin
    curWord = mem[wordIdx];
    byteSel = curWord[{AddrM[1:0], 3'b000} +: 8];
    halfSel = AddrM[1] ? curWord[31:16] : curWord[15:0];
    case (MemOpM)
      3'b001:  loadVal = {{16{halfSel[15]}}, halfSel};
      3'b010:  loadVal = {16'h0000, halfSel};
      3'b011:  loadVal = {{24{byteSel[7]}}, byteSel};
      3'b100:  loadVal = {24'h000000, byteSel};
      default: loadVal = curWord;
    endcase
    MemRDM = (MemReadM && !AddrErrM) ? loadVal : 32'h0;
  end

endmodule
